// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS instruction fetch front end.
package mips_pkg;

    localparam int unsigned INSN_W = 32;
    localparam logic [31:0] PC_STEP = 32'd4;
    localparam logic [INSN_W-1:0] NOP_INSN = 32'h0;

    // One prefetch ring entry: fetch address, returned word, word-present flag.
    typedef struct packed {
        logic [31:0]       pc;
        logic [INSN_W-1:0] word;
        logic              filled;
    } fetch_slot_t;

    // Sequential fetch address; wraps modulo 2^32.
    function automatic logic [31:0] pcAdvance(input logic [31:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/fetch_slot_ring.sv
// Prefetch ring: slots are allocated at the tail when a read is granted, filled
// in request order at the fill pointer, and retired from the head.
module fetch_slot_ring import mips_pkg::*; #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         allocEn,
    input  logic [31:0]                  allocPc,
    input  logic                         fillEn,
    input  logic [INSN_W-1:0]            fillWord,
    input  logic                         popEn,
    output logic [31:0]                  headPc,
    output logic [INSN_W-1:0]            headWord,
    output logic                         headFilled,
    output logic [$clog2(DEPTH+1)-1:0]   allocCnt,
    output logic [$clog2(DEPTH+1)-1:0]   unfilledCnt
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    fetch_slot_t           slots [DEPTH];
    logic [PtrW-1:0]       headPtr;
    logic [PtrW-1:0]       tailPtr;
    logic [PtrW-1:0]       fillPtr;

    // Head entry is presented straight from registered state.
    always_comb begin
        headPc     = slots[headPtr].pc;
        headWord   = slots[headPtr].word;
        headFilled = slots[headPtr].filled;
    end

    // Slot storage, pointers and occupancy counters; flush beats alloc/fill/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                slots[i] <= '{pc: '0, word: NOP_INSN, filled: 1'b0};
            end
            headPtr     <= '0;
            tailPtr     <= '0;
            fillPtr     <= '0;
            allocCnt    <= '0;
            unfilledCnt <= '0;
        end else if (flush) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                slots[i].filled <= 1'b0;
            end
            headPtr     <= tailPtr;
            fillPtr     <= tailPtr;
            allocCnt    <= '0;
            unfilledCnt <= '0;
        end else begin
            // Tail, fill and head slots are distinct whenever their enables coincide:
            // fill only hits already-allocated slots and pop only hits filled ones.
            if (allocEn) begin
                slots[tailPtr] <= '{pc: allocPc, word: NOP_INSN, filled: 1'b0};
                tailPtr        <= tailPtr + 1'b1;
            end
            if (fillEn) begin
                slots[fillPtr].word   <= fillWord;
                slots[fillPtr].filled <= 1'b1;
                fillPtr               <= fillPtr + 1'b1;
            end
            if (popEn) begin
                slots[headPtr].filled <= 1'b0;
                headPtr               <= headPtr + 1'b1;
            end
            allocCnt    <= allocCnt + CntW'(allocEn) - CntW'(popEn);
            unfilledCnt <= unfilledCnt + CntW'(allocEn) - CntW'(fillEn);
        end
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// IF-stage front end: owns the fetch PC, issues word reads to instruction
// memory and feeds the IF/ID register from a prefetch ring.
module instr_fetch_queue import mips_pkg::*; #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    input  logic              stall,
    output logic              imem_req,
    output logic [31:0]       imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [INSN_W-1:0] imem_rdata,
    output logic              if_valid,
    output logic [INSN_W-1:0] if_ins,
    output logic [31:0]       if_pc_plus4
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [31:0]       fetchPc;
    logic [CntW-1:0]   discardCnt;
    logic [CntW-1:0]   discardNext;
    logic [CntW-1:0]   outstandingCnt;
    logic [CntW-1:0]   allocCnt;
    logic [CntW-1:0]   unfilledCnt;
    logic              issue;
    logic              fillEn;
    logic              popEn;
    logic [31:0]       headPc;
    logic [INSN_W-1:0] headWord;
    logic              headFilled;

    fetch_slot_ring #(
        .DEPTH (DEPTH)
    ) u_ring (
        .clk         (clk),
        .rst         (rst),
        .flush       (redirect_valid),
        .allocEn     (issue),
        .allocPc     (fetchPc),
        .fillEn      (fillEn),
        .fillWord    (imem_rdata),
        .popEn       (popEn),
        .headPc      (headPc),
        .headWord    (headWord),
        .headFilled  (headFilled),
        .allocCnt    (allocCnt),
        .unfilledCnt (unfilledCnt)
    );

    // Issue, fill and pop decisions; redirect suppresses all of them.
    always_comb begin
        imem_req  = !rst && !redirect_valid && (allocCnt < CntW'(DEPTH));
        imem_addr = fetchPc;
        issue     = imem_req && imem_gnt;
        fillEn    = imem_rvalid && !redirect_valid && (discardCnt == '0);
        popEn     = headFilled && !stall;
    end

    // Stale-response accounting across redirects.
    always_comb begin
        discardNext = discardCnt;
        if (redirect_valid) begin
            // Every unfilled slot becomes a stale response; one arriving this cycle
            // retires an outstanding request whether it was stale or not.
            discardNext = discardCnt + unfilledCnt - CntW'(imem_rvalid);
        end else if (imem_rvalid && (discardCnt != '0)) begin
            discardNext = discardCnt - 1'b1;
        end
    end

    // IF/ID-facing view of the head slot; zeroed while no instruction is ready.
    always_comb begin
        if_valid    = headFilled;
        if_ins      = headFilled ? headWord : NOP_INSN;
        if_pc_plus4 = headFilled ? pcAdvance(headPc) : '0;
    end

    // Fetch PC, discard counter and outstanding-request tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetchPc        <= RESET_PC;
            discardCnt     <= '0;
            outstandingCnt <= '0;
        end else begin
            if (redirect_valid) begin
                fetchPc <= redirect_pc;
            end else if (issue) begin
                fetchPc <= pcAdvance(fetchPc);
            end
            discardCnt     <= discardNext;
            outstandingCnt <= outstandingCnt + CntW'(issue) - CntW'(imem_rvalid);
        end
    end

    // Every outstanding read is either owed to a ring slot or marked for discard.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (discardCnt + unfilledCnt == outstandingCnt)
                else $error("fetch queue: discard+unfilled != outstanding");
            assert (outstandingCnt <= CntW'(DEPTH))
                else $error("fetch queue: outstanding exceeds DEPTH");
            assert (!imem_rvalid || (outstandingCnt != '0))
                else $error("fetch queue: rvalid with no outstanding request");
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue with an in-order memory model (mem[k]=k).
module tb_instr_fetch_queue;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_ins;
    logic [31:0] if_pc_plus4;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          lat   = 1;
    logic [31:0] addrQ [$];
    int          dueQ  [$];

    instr_fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_ins         (if_ins),
        .if_pc_plus4    (if_pc_plus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic chkBit(input string tag, input logic got, input logic exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%b expected=%b", tag, got, exp);
        end
    endtask

    // Drive this cycle's control inputs and let outputs settle.
    task automatic setIn(input logic rd, input logic [31:0] rpc, input logic st, input logic g);
        redirect_valid = rd;
        redirect_pc    = rpc;
        stall          = st;
        imem_gnt       = g;
        #1;
    endtask

    // Advance one clock; the memory model records grants and returns data in order.
    task automatic step();
        logic        fire;
        logic [31:0] fireAddr;
        logic        wasRst;
        @(negedge clk);
        fire     = (imem_req === 1'b1) && (imem_gnt === 1'b1);
        fireAddr = imem_addr;
        wasRst   = rst;
        @(posedge clk);
        #1;
        cyc++;
        if (wasRst) begin
            addrQ.delete();
            dueQ.delete();
        end else if (fire) begin
            addrQ.push_back(fireAddr);
            dueQ.push_back(cyc - 1 + lat);
        end
        if (!wasRst && dueQ.size() > 0 && dueQ[0] <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = addrQ[0] >> 2;
            void'(addrQ.pop_front());
            void'(dueQ.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
    endtask

    task automatic resetDut();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        stall          = 1'b0;
        imem_gnt       = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        stall          = 1'b0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;

        // Reset state
        step();
        step();
        #1;
        chkBit("rst_req", imem_req, 1'b0);
        chkBit("rst_valid", if_valid, 1'b0);
        chk("rst_ins", if_ins, 32'h0);
        chk("rst_pc4", if_pc_plus4, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        step();
        rst = 1'b0;

        // 1: streaming with 1-cycle memory
        lat = 1;
        for (int i = 0; i < 8; i++) begin
            setIn(1'b0, 32'h0, 1'b0, 1'b1);
            chkBit("t1_req", imem_req, 1'b1);
            chk("t1_addr", imem_addr, 32'(4 * i));
            chkBit("t1_valid", if_valid, i >= 2);
            if (i >= 2) begin
                chk("t1_ins", if_ins, 32'(i - 2));
                chk("t1_pc4", if_pc_plus4, 32'(4 * (i - 1)));
            end
            step();
        end

        // 2: stall for 6 cycles, then drain
        for (int s = 0; s < 6; s++) begin
            setIn(1'b0, 32'h0, 1'b1, 1'b1);
            chkBit("t2_stall_valid", if_valid, 1'b1);
            chk("t2_stall_ins", if_ins, 32'd6);
            chk("t2_stall_pc4", if_pc_plus4, 32'd28);
            chkBit("t2_stall_req", imem_req, s < 2);
            step();
        end
        for (int s = 0; s < 5; s++) begin
            setIn(1'b0, 32'h0, 1'b0, 1'b1);
            chkBit("t2_drain_valid", if_valid, 1'b1);
            chk("t2_drain_ins", if_ins, 32'(6 + s));
            chk("t2_drain_pc4", if_pc_plus4, 32'(4 * (7 + s)));
            chkBit("t2_drain_req", imem_req, s > 0);
            if (s > 0) chk("t2_drain_addr", imem_addr, 32'(36 + 4 * s));
            step();
        end

        // 3: redirect with three reads in flight
        resetDut();
        lat = 4;
        for (int i = 0; i < 3; i++) begin
            setIn(1'b0, 32'h0, 1'b0, 1'b1);
            chk("t3_addr", imem_addr, 32'(4 * i));
            step();
        end
        setIn(1'b1, 32'h100, 1'b0, 1'b1);
        chkBit("t3_redir_req", imem_req, 1'b0);
        chkBit("t3_redir_valid", if_valid, 1'b0);
        step();
        for (int i = 0; i < 5; i++) begin
            setIn(1'b0, 32'h0, 1'b0, 1'b1);
            chkBit("t3_valid", if_valid, 1'b0);
            chkBit("t3_req", imem_req, i < 4);
            if (i < 4) chk("t3_addr_tgt", imem_addr, 32'h100 + 32'(4 * i));
            chk("t3_discard", 32'(dut.discardCnt), (i < 3) ? 32'(3 - i) : 32'h0);
            step();
        end
        setIn(1'b0, 32'h0, 1'b0, 1'b1);
        chkBit("t3_first_valid", if_valid, 1'b1);
        chk("t3_first_ins", if_ins, 32'h40);
        chk("t3_first_pc4", if_pc_plus4, 32'h104);
        step();
        setIn(1'b0, 32'h0, 1'b0, 1'b1);
        chk("t3_next_ins", if_ins, 32'h41);
        chk("t3_next_pc4", if_pc_plus4, 32'h108);
        step();

        // 4: redirect together with stall on a full ring
        resetDut();
        lat = 1;
        for (int i = 0; i < 5; i++) begin
            setIn(1'b0, 32'h0, 1'b1, 1'b1);
            chkBit("t4_fill_req", imem_req, i < 4);
            step();
        end
        setIn(1'b1, 32'h200, 1'b1, 1'b1);
        chkBit("t4_full_valid", if_valid, 1'b1);
        chk("t4_full_ins", if_ins, 32'h0);
        chk("t4_full_pc4", if_pc_plus4, 32'h4);
        chkBit("t4_redir_req", imem_req, 1'b0);
        step();
        setIn(1'b0, 32'h0, 1'b0, 1'b1);
        chkBit("t4_flushed_valid", if_valid, 1'b0);
        chk("t4_flushed_ins", if_ins, 32'h0);
        chkBit("t4_tgt_req", imem_req, 1'b1);
        chk("t4_tgt_addr", imem_addr, 32'h200);
        step();
        setIn(1'b0, 32'h0, 1'b0, 1'b1);
        chkBit("t4_wait_valid", if_valid, 1'b0);
        step();
        setIn(1'b0, 32'h0, 1'b0, 1'b1);
        chkBit("t4_tgt_valid", if_valid, 1'b1);
        chk("t4_tgt_ins", if_ins, 32'h80);
        chk("t4_tgt_pc4", if_pc_plus4, 32'h204);
        step();

        // 5: grant withheld for 5 cycles
        for (int i = 0; i < 5; i++) begin
            setIn(1'b0, 32'h0, 1'b0, 1'b0);
            chkBit("t5_req", imem_req, 1'b1);
            chk("t5_addr", imem_addr, 32'h20C);
            chkBit("t5_valid", if_valid, i < 2);
            if (i < 2) chk("t5_ins", if_ins, 32'h81 + 32'(i));
            step();
        end
        setIn(1'b0, 32'h0, 1'b0, 1'b1);
        chk("t5_resume_addr", imem_addr, 32'h20C);
        chkBit("t5_resume_valid", if_valid, 1'b0);
        step();
        setIn(1'b0, 32'h0, 1'b0, 1'b1);
        step();
        setIn(1'b0, 32'h0, 1'b0, 1'b1);
        chkBit("t5_after_valid", if_valid, 1'b1);
        chk("t5_after_ins", if_ins, 32'h83);
        chk("t5_after_pc4", if_pc_plus4, 32'h210);
        step();

        // 6: reset with two reads in flight and two filled slots
        resetDut();
        lat = 3;
        for (int i = 0; i < 5; i++) begin
            setIn(1'b0, 32'h0, 1'b1, 1'b1);
            chkBit("t6_req", imem_req, i < 4);
            if (i == 4) begin
                chkBit("t6_pre_valid", if_valid, 1'b1);
                chk("t6_pre_ins", if_ins, 32'h0);
            end
            step();
        end
        rst = 1'b1;
        setIn(1'b0, 32'h0, 1'b1, 1'b1);
        chkBit("t6_rst_req", imem_req, 1'b0);
        step();
        rst = 1'b0;
        setIn(1'b0, 32'h0, 1'b0, 1'b1);
        chkBit("t6_post_valid", if_valid, 1'b0);
        chk("t6_post_ins", if_ins, 32'h0);
        chk("t6_post_addr", imem_addr, 32'h0);
        chkBit("t6_post_req", imem_req, 1'b1);
        chk("t6_post_discard", 32'(dut.discardCnt), 32'h0);
        step();

        // 6b: fetch PC wraps past 0xFFFFFFFC
        resetDut();
        lat = 1;
        setIn(1'b1, 32'hFFFF_FFF8, 1'b0, 1'b1);
        chkBit("wrap_redir_req", imem_req, 1'b0);
        step();
        setIn(1'b0, 32'h0, 1'b0, 1'b1);
        chk("wrap_addr0", imem_addr, 32'hFFFF_FFF8);
        step();
        setIn(1'b0, 32'h0, 1'b0, 1'b1);
        chk("wrap_addr1", imem_addr, 32'hFFFF_FFFC);
        step();
        setIn(1'b0, 32'h0, 1'b0, 1'b1);
        chk("wrap_addr2", imem_addr, 32'h0);
        chkBit("wrap_valid", if_valid, 1'b1);
        chk("wrap_ins0", if_ins, 32'h3FFF_FFFE);
        chk("wrap_pc4_0", if_pc_plus4, 32'hFFFF_FFFC);
        step();
        setIn(1'b0, 32'h0, 1'b0, 1'b1);
        chk("wrap_ins1", if_ins, 32'h3FFF_FFFF);
        chk("wrap_pc4_1", if_pc_plus4, 32'h0);
        chk("wrap_addr3", imem_addr, 32'h4);
        step();
        setIn(1'b0, 32'h0, 1'b0, 1'b1);
        chk("wrap_ins2", if_ins, 32'h0);
        chk("wrap_pc4_2", if_pc_plus4, 32'h4);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
